// File: rtl/out_switch_ctrl_pkg.sv
// Shared types and default timing constants for the output source switch sequencer.
package out_switch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    TXRST,
    SETTLE
  } swState_e;

  localparam int unsigned DefBlankFrames = 2;
  localparam int unsigned DefTxRstCycles = 270;
  localparam int unsigned DefVsTimeout   = 1000000;
  localparam int unsigned TimeoutWidth   = 20;

endpackage

// File: rtl/out_switch_ctrl_vs_edge_sync.sv
// Two-flop VSYNC synchronizer followed by a one-cycle falling-edge pulse.
module vs_edge_sync
  import out_switch_ctrl_pkg::*;
(
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic vs_i,
  output logic fall_o
);

  // [0] and [1] form the synchronizer, [2] holds the previous synchronized level
  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], vs_i};
    end
  end

  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/out_switch_ctrl.sv
// Output source switch sequencer: blank, swap the mux, reset the HDMI TX, then wait
// for the new source to settle. Define SWITCH_TXRST_EN to enable the TX reset pulse.
module out_switch_ctrl
  import out_switch_ctrl_pkg::*;
#(
  parameter int unsigned BLANK_FRAMES  = DefBlankFrames,
  parameter int unsigned TX_RST_CYCLES = DefTxRstCycles,
  parameter int unsigned VS_TIMEOUT    = DefVsTimeout
) (
  input  logic       clk27,
  input  logic       reset_n,
  input  logic       src_req,
  input  logic       vs_sc,
  input  logic       vs_vg,
  output logic       sel_out,
  output logic       blank_out,
  output logic       tx_rst_n_out,
  output logic       busy,
  output logic [7:0] switch_cnt,
  output logic       timeout_flag
);

  localparam logic [TimeoutWidth-1:0] TimeoutLast = TimeoutWidth'(VS_TIMEOUT - 1);
  localparam logic [TimeoutWidth-1:0] CntOne      = TimeoutWidth'(1);
  localparam logic [3:0]              FramesLast  = 4'(BLANK_FRAMES - 1);

  if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_badFrames
    $error("BLANK_FRAMES must be within 1..15");
  end
  if (TX_RST_CYCLES < 1 || TX_RST_CYCLES > 1048575) begin : g_badTxRst
    $error("TX_RST_CYCLES must be within 1..2^20-1");
  end
  if (VS_TIMEOUT < 1 || VS_TIMEOUT > 1048575) begin : g_badTimeout
    $error("VS_TIMEOUT must be within 1..2^20-1");
  end

  swState_e                  state_q, state_d;
  logic                      sel_q, sel_d;
  logic [3:0]                edgeCnt_q, edgeCnt_d;
  logic [TimeoutWidth-1:0]   timeoutCnt_q, timeoutCnt_d;
  logic [7:0]                switchCnt_q, switchCnt_d;
  logic                      timeoutFlag_q, timeoutFlag_d;
  logic                      initSeq_q, initSeq_d;
  logic                      scFall, vgFall, selEdge, timeoutHit;

  vs_edge_sync u_syncSc (
    .clk_i   (clk27),
    .rst_n_i (reset_n),
    .vs_i    (vs_sc),
    .fall_o  (scFall)
  );

  vs_edge_sync u_syncVg (
    .clk_i   (clk27),
    .rst_n_i (reset_n),
    .vs_i    (vs_vg),
    .fall_o  (vgFall)
  );

  assign selEdge    = sel_q ? vgFall : scFall;
  assign timeoutHit = (timeoutCnt_q == TimeoutLast);

`ifdef SWITCH_TXRST_EN
  localparam logic [TimeoutWidth-1:0] TxRstLast = TimeoutWidth'(TX_RST_CYCLES - 1);

  logic [TimeoutWidth-1:0] txCnt_q, txCnt_d;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      txCnt_q <= '0;
    end else begin
      txCnt_q <= txCnt_d;
    end
  end
`endif

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= TXRST;
      sel_q         <= 1'b1;
      edgeCnt_q     <= '0;
      timeoutCnt_q  <= '0;
      switchCnt_q   <= '0;
      timeoutFlag_q <= 1'b0;
      initSeq_q     <= 1'b1;
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      edgeCnt_q     <= edgeCnt_d;
      timeoutCnt_q  <= timeoutCnt_d;
      switchCnt_q   <= switchCnt_d;
      timeoutFlag_q <= timeoutFlag_d;
      initSeq_q     <= initSeq_d;
    end
  end

  // The timeout counter only runs while waiting on VSYNC and restarts on every entry
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    edgeCnt_d     = edgeCnt_q;
    timeoutCnt_d  = '0;
    switchCnt_d   = switchCnt_q;
    timeoutFlag_d = timeoutFlag_q;
    initSeq_d     = initSeq_q;
`ifdef SWITCH_TXRST_EN
    txCnt_d       = '0;
`endif
    case (state_q)
      IDLE: begin
        if (src_req != sel_q) begin
          state_d       = DRAIN;
          timeoutFlag_d = 1'b0;
        end
      end
      DRAIN: begin
        timeoutCnt_d = timeoutCnt_q + CntOne;
        if (selEdge || timeoutHit) begin
          state_d      = TXRST;
          sel_d        = ~sel_q;
          timeoutCnt_d = '0;
        end
      end
      TXRST: begin
        edgeCnt_d = '0;
`ifdef SWITCH_TXRST_EN
        txCnt_d = txCnt_q + CntOne;
        if (txCnt_q == TxRstLast) begin
          state_d = SETTLE;
          txCnt_d = '0;
        end
`else
        state_d = SETTLE;
`endif
      end
      SETTLE: begin
        timeoutCnt_d = timeoutCnt_q + CntOne;
        // A coincident edge wins over the timeout, so the flag only marks a missing VSYNC
        if (selEdge || timeoutHit) begin
          timeoutCnt_d = '0;
          if (!selEdge) begin
            timeoutFlag_d = 1'b1;
          end
          if (edgeCnt_q == FramesLast) begin
            state_d   = IDLE;
            edgeCnt_d = '0;
            initSeq_d = 1'b0;
            if (!initSeq_q) begin
              switchCnt_d = switchCnt_q + 8'd1;
            end
          end else begin
            edgeCnt_d = edgeCnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel_out      = sel_q;
  assign blank_out    = (state_q != IDLE);
  assign busy         = (state_q != IDLE);
  assign switch_cnt   = switchCnt_q;
  assign timeout_flag = timeoutFlag_q;

`ifdef SWITCH_TXRST_EN
  assign tx_rst_n_out = (state_q != TXRST);
`else
  assign tx_rst_n_out = 1'b1;
`endif

endmodule

// File: tb/tb_out_switch_ctrl.sv
// Self-checking bench for out_switch_ctrl: a directed vector table for a plain switch
// plus hand sequences for timeouts, back-to-back switches and a mid-sequence reset.
module tb_out_switch_ctrl;

`ifdef SWITCH_TXRST_EN
  localparam logic TxLow       = 1'b0;
  localparam int   TxLen       = 16;
  localparam int   TxLowCycles = 16;
`else
  localparam logic TxLow       = 1'b1;
  localparam int   TxLen       = 1;
  localparam int   TxLowCycles = 0;
`endif

  logic       clk27   = 1'b0;
  logic       reset_n = 1'b1;
  logic       src_req = 1'b1;
  logic       vs_sc   = 1'b1;
  logic       vs_vg   = 1'b1;
  logic       sel_out;
  logic       blank_out;
  logic       tx_rst_n_out;
  logic       busy;
  logic [7:0] switch_cnt;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rstN;
    logic       src;
    logic       sc;
    logic       vg;
    int         cycles;
    logic       eSel;
    logic       eBlank;
    logic       eTxN;
    logic       eBusy;
    logic [7:0] eCnt;
    logic       eFlag;
  } vec_t;

  vec_t vecs[13];

  out_switch_ctrl #(
    .BLANK_FRAMES  (2),
    .TX_RST_CYCLES (16),
    .VS_TIMEOUT    (1000)
  ) dut (
    .clk27        (clk27),
    .reset_n      (reset_n),
    .src_req      (src_req),
    .vs_sc        (vs_sc),
    .vs_vg        (vs_vg),
    .sel_out      (sel_out),
    .blank_out    (blank_out),
    .tx_rst_n_out (tx_rst_n_out),
    .busy         (busy),
    .switch_cnt   (switch_cnt),
    .timeout_flag (timeout_flag)
  );

  always #5 clk27 = ~clk27;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk27);
      #1;
    end
  endtask

  function automatic vec_t mkVec(input logic rstN, src, sc, vg, input int cycles,
                                 input logic eSel, eBlank, eTxN, eBusy,
                                 input logic [7:0] eCnt, input logic eFlag);
    vec_t v;
    v.rstN = rstN; v.src = src; v.sc = sc; v.vg = vg; v.cycles = cycles;
    v.eSel = eSel; v.eBlank = eBlank; v.eTxN = eTxN; v.eBusy = eBusy;
    v.eCnt = eCnt; v.eFlag = eFlag;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset_n = v.rstN;
    src_req = v.src;
    vs_sc   = v.sc;
    vs_vg   = v.vg;
    step(v.cycles);
  endtask

  task automatic checkOutput(input string name, input logic eSel, eBlank, eTxN, eBusy,
                             input logic [7:0] eCnt, input logic eFlag);
    checks++;
    if ({sel_out, blank_out, tx_rst_n_out, busy, switch_cnt, timeout_flag} !==
        {eSel, eBlank, eTxN, eBusy, eCnt, eFlag}) begin
      errors++;
      $display("[TB] FAIL %s: got sel=%b blank=%b txrstn=%b busy=%b cnt=%0d flag=%b, want sel=%b blank=%b txrstn=%b busy=%b cnt=%0d flag=%b",
               name, sel_out, blank_out, tx_rst_n_out, busy, switch_cnt, timeout_flag,
               eSel, eBlank, eTxN, eBusy, eCnt, eFlag);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lowCount;

    // Plain sc switch from sel=1, with a non-selected vs_sc edge inside DRAIN
    vecs[0]  = mkVec(1, 1, 1, 1,  20, 1, 0, 1,     0, 8'd0, 0);
    vecs[1]  = mkVec(1, 0, 1, 1,   1, 1, 1, 1,     1, 8'd0, 0);
    vecs[2]  = mkVec(1, 0, 0, 1,  10, 1, 1, 1,     1, 8'd0, 0);
    vecs[3]  = mkVec(1, 0, 1, 1,  50, 1, 1, 1,     1, 8'd0, 0);
    vecs[4]  = mkVec(1, 0, 1, 0,   2, 1, 1, 1,     1, 8'd0, 0);
    vecs[5]  = mkVec(1, 0, 1, 0,   1, 0, 1, TxLow, 1, 8'd0, 0);
    vecs[6]  = mkVec(1, 0, 1, 0,  15, 0, 1, TxLow, 1, 8'd0, 0);
    vecs[7]  = mkVec(1, 0, 1, 0,   1, 0, 1, 1,     1, 8'd0, 0);
    vecs[8]  = mkVec(1, 0, 1, 0, 100, 0, 1, 1,     1, 8'd0, 0);
    vecs[9]  = mkVec(1, 0, 0, 0, 100, 0, 1, 1,     1, 8'd0, 0);
    vecs[10] = mkVec(1, 0, 1, 0, 100, 0, 1, 1,     1, 8'd0, 0);
    vecs[11] = mkVec(1, 0, 0, 0,   2, 0, 1, 1,     1, 8'd0, 0);
    vecs[12] = mkVec(1, 0, 0, 0,   1, 0, 0, 1,     0, 8'd1, 0);

    // Power-on reset and initial videogen settle
    #2 reset_n = 1'b0;
    #1 checkOutput("resetAsync", 1, 1, TxLow, 1, 8'd0, 0);
    step(3);
    checkOutput("resetHeld", 1, 1, TxLow, 1, 8'd0, 0);
    reset_n = 1'b1;
    lowCount = 0;
    while (tx_rst_n_out == 1'b0 && lowCount < 100) begin
      lowCount++;
      step(1);
    end
    checkValue("txRstLowCycles", lowCount, TxLowCycles);
    checkOutput("afterTxRst", 1, 1, 1, 1, 8'd0, 0);
    step(200); vs_vg = 1'b0;
    step(200); vs_vg = 1'b1;
    step(200); vs_vg = 1'b0;
    step(2);
    checkOutput("initBeforeUnblank", 1, 1, 1, 1, 8'd0, 0);
    step(1);
    checkOutput("initUnblank", 1, 0, 1, 0, 8'd0, 0);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i].eSel, vecs[i].eBlank, vecs[i].eTxN,
                  vecs[i].eBusy, vecs[i].eCnt, vecs[i].eFlag);
    end

    // DRAIN timeout: switch to videogen while vs_sc stays high
    vs_sc = 1'b1; step(5);
    src_req = 1'b1; step(1);
    checkOutput("toDrainEntry", 0, 1, 1, 1, 8'd1, 0);
    step(999);
    checkOutput("toDrainLast", 0, 1, 1, 1, 8'd1, 0);
    step(1);
    checkOutput("toDrainExit", 1, 1, TxLow, 1, 8'd1, 0);
    step(50);  vs_vg = 1'b1;
    step(100); vs_vg = 1'b0;
    step(100); vs_vg = 1'b1;
    step(100); vs_vg = 1'b0;
    step(3);
    checkOutput("toDone", 1, 0, 1, 0, 8'd2, 0);

    // src_req bounces 1->0->1 inside DRAIN: two back-to-back switches
    src_req = 1'b0; step(1);
    checkOutput("bounceDrain", 1, 1, 1, 1, 8'd2, 0);
    src_req = 1'b1; step(5);
    checkOutput("bounceStillDrain", 1, 1, 1, 1, 8'd2, 0);
    vs_vg = 1'b1; step(10);
    vs_vg = 1'b0; step(3);
    checkOutput("bounceFlip1", 0, 1, TxLow, 1, 8'd2, 0);
    step(50);  vs_sc = 1'b0;
    step(100); vs_sc = 1'b1;
    step(100); vs_sc = 1'b0;
    step(3);
    checkOutput("bounceFirstDone", 0, 0, 1, 0, 8'd3, 0);
    step(1);
    checkOutput("bounceRestart", 0, 1, 1, 1, 8'd3, 0);
    vs_sc = 1'b1; step(10);
    vs_sc = 1'b0; step(3);
    checkOutput("bounceFlip2", 1, 1, TxLow, 1, 8'd3, 0);
    step(50);  vs_vg = 1'b1;
    step(100); vs_vg = 1'b0;
    step(100); vs_vg = 1'b1;
    step(100); vs_vg = 1'b0;
    step(3);
    checkOutput("bounceSecondDone", 1, 0, 1, 0, 8'd4, 0);

    // vs_sc stuck low in SETTLE: two timeouts complete the switch and set the flag
    src_req = 1'b0; step(1);
    checkOutput("stuckDrain", 1, 1, 1, 1, 8'd4, 0);
    vs_vg = 1'b1; step(10);
    vs_vg = 1'b0; step(3);
    checkOutput("stuckFlip", 0, 1, TxLow, 1, 8'd4, 0);
    step(TxLen + 999);
    checkOutput("stuckBeforeTo1", 0, 1, 1, 1, 8'd4, 0);
    step(1);
    checkOutput("stuckTo1", 0, 1, 1, 1, 8'd4, 1);
    step(999);
    checkOutput("stuckBeforeTo2", 0, 1, 1, 1, 8'd4, 1);
    step(1);
    checkOutput("stuckDone", 0, 0, 1, 0, 8'd5, 1);

    // Reset in the middle of SETTLE aborts the sequence asynchronously
    src_req = 1'b1; step(1);
    checkOutput("rstDrainFlagClr", 0, 1, 1, 1, 8'd5, 0);
    vs_sc = 1'b1; step(10);
    vs_sc = 1'b0; step(3);
    checkOutput("rstFlip", 1, 1, TxLow, 1, 8'd5, 0);
    step(TxLen + 1010);
    checkOutput("rstMidSettle", 1, 1, 1, 1, 8'd5, 1);
    reset_n = 1'b0;
    #2 checkOutput("rstAbortSameCycle", 1, 1, TxLow, 1, 8'd0, 0);
    step(3);
    checkOutput("rstAbortHeld", 1, 1, TxLow, 1, 8'd0, 0);
    reset_n = 1'b1;
    step(5);
    checkOutput("rstReleased", 1, 1, (TxLen > 5) ? TxLow : 1'b1, 1, 8'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
